// File: rtl/mips_defs.sv
// Shared MIPS decode definitions used by decode_stage and the downstream ALU.
// Contents:
//   - opcode / funct field constants
//   - 4-bit ALU operation codes (the ALU decodes this same enum)
//   - 16-bit immediate sign/zero extension helpers
package mips_defs;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // rt field value selecting bgez within the REGIMM opcode group
  localparam logic [4:0] RI_BGEZ = 5'b00001;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_NOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_ADDU = 4'b1010,
    ALU_SUBU = 4'b1011,
    ALU_BGTZ = 4'b1100,
    ALU_BGEZ = 4'b1101,
    ALU_BNE  = 4'b1110,
    ALU_LUI  = 4'b1111
  } alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero, write-through bypass so a
// read in the same cycle as a write to that register sees the new data.
// Ports:
//   clock, reset_n          clock / async active-low reset (clears all regs)
//   rd_addr_a/b, rd_data_a/b  read ports
//   wr_en, wr_addr, wr_data   write port
module reg_file #(
  parameter int REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] mem_q [REG_COUNT];
  logic        wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
    end else if (wr_live) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != 5'd0)
      rd_data_a = (wr_live && wr_addr == rd_addr_a) ? wr_data : mem_q[rd_addr_a];
    if (rd_addr_b != 5'd0)
      rd_data_b = (wr_live && wr_addr == rd_addr_b) ? wr_data : mem_q[rd_addr_b];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage feeding the ALU. Reads rs/rt from the
// register file, decodes opcode/funct to an ALU operation, selects the
// immediate operand and registers the resulting bundle (1-cycle latency).
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   instr, instr_valid              fetched instruction and its qualifier
//   stall, flush                    hold outputs / inject a bubble (flush wins)
//   wb_en, wb_addr, wb_data         register-file write port from writeback
//   rs/rs_unsigned, rt/rt_unsigned  operand A / operand B (same bits)
//   alu_op, shamt                   ALU operation and shift amount
//   dest_reg, reg_write             writeback destination and enable
//   out_valid, illegal              bundle valid / unrecognised instruction
module decode_stage
  import mips_defs::*;
#(
  parameter int RESET_PC_NOP = 1,
  parameter int REG_COUNT    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [31:0]        wb_data,
  output logic signed [31:0] rs,
  output logic [31:0]        rs_unsigned,
  output logic signed [31:0] rt,
  output logic [31:0]        rt_unsigned,
  output logic [3:0]         alu_op,
  output logic [4:0]         shamt,
  output logic [4:0]         dest_reg,
  output logic               reg_write,
  output logic               out_valid,
  output logic               illegal
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [15:0] imm;
  logic [31:0] rs_rdata, rt_rdata;

  assign opcode = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  reg_file #(.REG_COUNT(REG_COUNT)) u_reg_file (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr_a (rs_idx),
    .rd_addr_b (rt_idx),
    .rd_data_a (rs_rdata),
    .rd_data_b (rt_rdata),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  alu_op_e     dec_op;
  logic [4:0]  dec_dest;
  logic        dec_rw, dec_ill;
  logic [31:0] dec_rt;

  always_comb begin
    dec_op   = ALU_NONE;
    dec_dest = '0;
    dec_rw   = 1'b0;
    dec_ill  = 1'b0;
    dec_rt   = rt_rdata;
    unique case (opcode)
      OP_RTYPE: begin
        dec_dest = rd_idx;
        dec_rw   = 1'b1;
        unique case (funct)
          FN_ADD:  dec_op = ALU_ADD;
          FN_ADDU: dec_op = ALU_ADDU;
          FN_SUB:  dec_op = ALU_SUB;
          FN_SUBU: dec_op = ALU_SUBU;
          FN_AND:  dec_op = ALU_AND;
          FN_OR:   dec_op = ALU_OR;
          FN_NOR:  dec_op = ALU_NOR;
          FN_SLT:  dec_op = ALU_SLT;
          FN_SLL:  dec_op = ALU_SLL;
          FN_SRL:  dec_op = ALU_SRL;
          FN_SRA:  dec_op = ALU_SRA;
          default: begin
            dec_dest = '0;
            dec_rw   = 1'b0;
            dec_ill  = 1'b1;
          end
        endcase
      end
      OP_ADDI:  begin dec_op = ALU_ADD;  dec_rt = sign_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_ADDIU: begin dec_op = ALU_ADDU; dec_rt = sign_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_SLTI:  begin dec_op = ALU_SLT;  dec_rt = sign_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_ANDI:  begin dec_op = ALU_AND;  dec_rt = zero_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_ORI:   begin dec_op = ALU_OR;   dec_rt = zero_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_LUI:   begin dec_op = ALU_LUI;  dec_rt = zero_ext16(imm); dec_dest = rt_idx; dec_rw = 1'b1; end
      OP_BEQ:   dec_op = ALU_SUB;
      OP_BNE:   dec_op = ALU_BNE;
      OP_BGTZ:  dec_op = ALU_BGTZ;
      OP_REGIMM: begin
        if (rt_idx == RI_BGEZ) dec_op = ALU_BGEZ;
        else                   dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  logic [31:0] rs_d, rs_q, rt_d, rt_q;
  logic [3:0]  alu_op_d, alu_op_q;
  logic [4:0]  shamt_d, shamt_q, dest_d, dest_q;
  logic        reg_write_d, reg_write_q, out_valid_d, out_valid_q, illegal_d, illegal_q;
  logic        is_nop, bubble;

  // All-zero word is the post-reset fetch filler; treat it as a bubble so it
  // does not masquerade as a real sll r0,r0,0.
  assign is_nop = (RESET_PC_NOP != 0) && (instr == 32'h0);
  assign bubble = flush || (!stall && (!instr_valid || is_nop));

  always_comb begin
    rs_d        = rs_q;
    rt_d        = rt_q;
    alu_op_d    = alu_op_q;
    shamt_d     = shamt_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    if (bubble) begin
      rs_d        = '0;
      rt_d        = '0;
      alu_op_d    = ALU_NONE;
      shamt_d     = '0;
      dest_d      = '0;
      reg_write_d = 1'b0;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      rs_d        = rs_rdata;
      rt_d        = dec_rt;
      alu_op_d    = dec_op;
      shamt_d     = instr[10:6];
      dest_d      = dec_dest;
      reg_write_d = dec_rw && (dec_dest != 5'd0);
      out_valid_d = 1'b1;
      illegal_d   = dec_ill;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs_q        <= '0;
      rt_q        <= '0;
      alu_op_q    <= ALU_NONE;
      shamt_q     <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      alu_op_q    <= alu_op_d;
      shamt_q     <= shamt_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign rs          = rs_q;
  assign rs_unsigned = rs_q;
  assign rt          = rt_q;
  assign rt_unsigned = rt_q;
  assign alu_op      = alu_op_q;
  assign shamt       = shamt_q;
  assign dest_reg    = dest_q;
  assign reg_write   = reg_write_q;
  assign out_valid   = out_valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [31:0]        instr;
  logic               instr_valid, stall, flush, wb_en;
  logic [4:0]         wb_addr;
  logic [31:0]        wb_data;
  logic signed [31:0] rs, rt;
  logic [31:0]        rs_unsigned, rt_unsigned;
  logic [3:0]         alu_op;
  logic [4:0]         shamt, dest_reg;
  logic               reg_write, out_valid, illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(.RESET_PC_NOP(1), .REG_COUNT(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rs          (rs),
    .rs_unsigned (rs_unsigned),
    .rt          (rt),
    .rt_unsigned (rt_unsigned),
    .alu_op      (alu_op),
    .shamt       (shamt),
    .dest_reg    (dest_reg),
    .reg_write   (reg_write),
    .out_valid   (out_valid),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks the whole bundle in one call.
  task automatic chk_bundle(input string tag, input logic [31:0] e_rs, input logic [31:0] e_rt,
                            input logic [3:0] e_op, input logic [4:0] e_dest,
                            input logic e_rw, input logic e_valid, input logic e_ill);
    chk({tag, ".rs"},        rs_unsigned, e_rs);
    chk({tag, ".rt"},        rt_unsigned, e_rt);
    chk({tag, ".alu_op"},    {28'h0, alu_op}, {28'h0, e_op});
    chk({tag, ".dest_reg"},  {27'h0, dest_reg}, {27'h0, e_dest});
    chk({tag, ".reg_write"}, {31'h0, reg_write}, {31'h0, e_rw});
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, e_valid});
    chk({tag, ".illegal"},   {31'h0, illegal}, {31'h0, e_ill});
  endtask

  initial begin
    reset_n = 1'b0; instr = '0; instr_valid = 0; stall = 0; flush = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    chk_bundle("reset", 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0);
    chk("reset.shamt", {27'h0, shamt}, 32'h0);
    @(negedge clock); reset_n = 1'b1;

    // preload r1=5, r2=7
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'd5; tick();
    wb_addr = 5'd2; wb_data = 32'd7; tick();
    wb_en = 0;

    instr = 32'h00221820; instr_valid = 1; tick();          // add r3,r1,r2
    chk_bundle("add", 32'd5, 32'd7, 4'b0001, 5'd3, 1, 1, 0);
    chk("add.rs_signed", rs, 32'd5);

    wb_en = 1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF; tick();   // bypass
    chk("bypass.rs", rs_unsigned, 32'hDEADBEEF);
    chk("bypass.rt", rt_unsigned, 32'd7);

    wb_addr = 5'd0; wb_data = 32'h1234; instr = 32'h00021820; tick(); // add r3,r0,r2
    chk("r0_write.rs", rs_unsigned, 32'h0);
    wb_en = 0;

    instr = 32'h3C041234; tick();                           // lui r4,0x1234
    chk_bundle("lui", 32'h0, 32'h00001234, 4'b1111, 5'd4, 1, 1, 0);

    instr = 32'h2005FFFF; tick();                           // addi r5,r0,-1
    chk_bundle("addi", 32'h0, 32'hFFFFFFFF, 4'b0001, 5'd5, 1, 1, 0);

    instr = 32'h3026FFFF; tick();                           // andi r6,r1,0xffff
    chk_bundle("andi", 32'hDEADBEEF, 32'h0000FFFF, 4'b0011, 5'd6, 1, 1, 0);

    instr = 32'h14220004; tick();                           // bne r1,r2
    chk_bundle("bne", 32'hDEADBEEF, 32'd7, 4'b1110, 5'd0, 0, 1, 0);

    instr = 32'hFC000000; tick();                           // opcode 3F
    chk("illegal.flag", {31'h0, illegal}, 32'h1);
    chk("illegal.alu_op", {28'h0, alu_op}, 32'h0);
    chk("illegal.reg_write", {31'h0, reg_write}, 32'h0);

    instr = 32'h00223822; tick();                           // sub r7,r1,r2
    chk_bundle("sub", 32'hDEADBEEF, 32'd7, 4'b0010, 5'd7, 1, 1, 0);

    instr = 32'h00024100; tick();                           // sll r8,r2,4
    chk("sll.alu_op", {28'h0, alu_op}, 32'h7);
    chk("sll.shamt", {27'h0, shamt}, 32'd4);
    chk("sll.dest", {27'h0, dest_reg}, 32'd8);

    instr = 32'h00000000; tick();                           // all-zero word
    chk_bundle("nop", 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0);

    instr = 32'h00220020; tick();                           // add r0,r1,r2
    chk_bundle("dest_r0", 32'hDEADBEEF, 32'd7, 4'b0001, 5'd0, 0, 1, 0);

    instr = 32'h00221820; tick();                           // add r3,r1,r2
    stall = 1; instr = 32'h3C041234;
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bundle("stall", 32'hDEADBEEF, 32'd7, 4'b0001, 5'd3, 1, 1, 0);
      wb_en = 0;
    end

    flush = 1; tick();
    chk("flush.out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush.alu_op", {28'h0, alu_op}, 32'h0);
    flush = 0; stall = 0;

    instr = 32'h01205020; tick();                           // add r10,r9,r0
    chk_bundle("wb_during_stall", 32'h99, 32'h0, 4'b0001, 5'd10, 1, 1, 0);

    instr_valid = 0; tick();
    chk_bundle("invalid", 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0);

    // asynchronous reset mid-cycle with an instruction pending
    instr_valid = 1; instr = 32'h00221820; tick();
    chk("pre_reset.out_valid", {31'h0, out_valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk_bundle("async_reset", 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0);
    @(negedge clock); reset_n = 1'b1;
    tick();
    chk_bundle("post_reset", 32'h0, 32'h0, 4'b0001, 5'd3, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage directly upstream of the ALU.
- Takes a fetched 32-bit MIPS instruction and reads rs/rt from an internal 32x32 register file.
- Decodes opcode/funct into the 4-bit ALU operation code, selects the immediate operand, and presents a registered operand bundle that the ALU samples on the following falling clock edge.
- Also owns the register-file write port used by writeback.

Parameters:
- RESET_PC_NOP, 1, when 1 an instruction word of all zeros decodes as a bubble (alu_op 0000) rather than sll r0,r0,0.
- REG_COUNT, 32, number of architectural registers; fixed at 32, present for documentation only.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  32  fetched instruction.
- instr_valid  in  1  instr is meaningful this cycle.
- stall  in  1  hold all output registers.
- flush  in  1  replace next output with a bubble.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write destination.
- wb_data  in  32  write data.
- rs  out  32  signed operand A.
- rs_unsigned  out  32  same bits as rs.
- rt  out  32  signed operand B (register or immediate).
- rt_unsigned  out  32  same bits as rt.
- alu_op  out  4  ALU operation code.
- shamt  out  5  shift amount, instr[10:6].
- dest_reg  out  5  writeback register.
- reg_write  out  1  result must be written back.
- out_valid  out  1  bundle is valid.
- illegal  out  1  unrecognised instruction.

Behaviour:
- Reset (asynchronous, reset_n=0): every output register clears to 0 (alu_op=0000, out_valid=0, illegal=0); all 32 registers clear to 0. Reset mid-operation discards the in-flight bundle; first valid output appears one rising edge after reset_n rises with instr_valid=1.
- Latency: 1 cycle. instr sampled at rising edge N, outputs valid after edge N; the ALU consumes them at the falling edge of cycle N.
- Register file:
  - Two asynchronous read ports indexed by instr[25:21] and instr[20:16].
  - One synchronous write port.
  - r0 always reads 0; writes to r0 are ignored.
  - Write-through bypass: if wb_en and wb_addr equals a read index (nonzero) in the same cycle, the read returns wb_data.
- Decode (opcode instr[31:26], funct instr[5:0]):
  - R-type (opcode 00):
    - funct 20 -> 0001; 21 -> 1010; 22 -> 0010; 23 -> 1011; 24 -> 0011; 25 -> 0100; 27 -> 0101; 2A -> 0110; 00 -> 0111; 02 -> 1000; 03 -> 1001.
    - dest_reg=rd, reg_write=1.
  - Immediate forms:
    - addi 08 -> 0001, sign-extended imm.
    - addiu 09 -> 1010, sign-extended imm.
    - slti 0A -> 0110, sign-extended imm.
    - andi 0C -> 0011, zero-extended imm.
    - ori 0D -> 0100, zero-extended imm.
    - lui 0F -> 1111, rt=zero-extended imm (ALU shifts left by 16).
    - For all immediate forms: dest_reg=instr[20:16], reg_write=1.
  - Branches (reg_write=0, dest_reg=0):
    - beq 04 -> 0010.
    - bne 05 -> 1110.
    - bgtz 07 -> 1100.
    - opcode 01 with instr[20:16]=00001 (bgez) -> 1101.
  - Any other opcode/funct: alu_op=0000, reg_write=0, illegal=1 (only when instr_valid).
  - reg_write is forced to 0 whenever dest_reg=0.
  - All-zero word with RESET_PC_NOP=1: bubble, illegal=0.
- instr_valid=0: next output is a bubble (out_valid=0, alu_op=0000, reg_write=0, illegal=0). Operand fields are don't-care but are driven to 0.
- stall=1: all output registers hold. Register-file writes still occur.
- flush=1: next output is a bubble regardless of stall or instr_valid (flush has priority over stall).

Decomposition:
- Shared package mips_defs holds:
  - opcode and funct constants;
  - the 4-bit ALU operation codes (ALU_NONE=0000 … ALU_LUI=1111), shared verbatim with the ALU;
  - sign/zero-extension helper functions.
- One sub-module: reg_file (32x32, 2R/1W, r0 hardwired zero, write-through bypass). Decode logic and output registers stay in decode_stage.

Test Plan:
- Reset applied mid-stream with instr=add r3,r1,r2 pending -> all outputs 0 immediately; after release, reading r1 returns 0.
- Write r1=5 and r2=7 via wb; then instr=0x00221820 (add r3,r1,r2) -> after one edge rs=5, rt=7, alu_op=0001, dest_reg=3, reg_write=1, out_valid=1.
- wb_en=1, wb_addr=1, wb_data=0xDEADBEEF in the same cycle as instr reads r1 -> rs=0xDEADBEEF (bypass). wb_addr=0 -> r0 still reads 0.
- lui r4,0x1234 -> rt=0x00001234, alu_op=1111, dest_reg=4. addi r5,r0,-1 -> rt=0xFFFFFFFF, alu_op=0001.
- bne r1,r2 -> alu_op=1110, reg_write=0. Unknown opcode 3F -> illegal=1, alu_op=0000.
- stall=1 for 3 cycles -> outputs unchanged. flush=1 together with stall=1 -> next output out_valid=0, alu_op=0000.
